mips_mem_arbiter: RTL and testbench
===================================

# mips_mem_arbiter

Single-port memory arbiter for the pipelined MIPS32 core's unified `Mem`. It shares one memory port between three requesters:
- instruction fetch (IF stage, read only),
- data access (MEM stage, `LW`/`SW`),
- a debug/loader port used to preload programs and inspect results.

It resolves conflicts with fixed priority plus starvation aging, and tracks which requester owns each read's returning data.

## Interface
Parameters:
- `ADDR_W`, default 10: word address width.
- `DATA_W`, default 32: data width.
- `STARVE_MAX`, default 4: consecutive denied cycles after which IF or DBG is promoted; legal range 1..15.

Ports:
- `clk1` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `halted` input 1: core `HALTED` flag.
- `if_req` input 1, `if_addr` input ADDR_W: fetch request and address.
- `if_gnt` output 1, `if_rvalid` output 1, `if_rdata` output DATA_W.
- `dm_req` input 1, `dm_we` input 1, `dm_addr` input ADDR_W, `dm_wdata` input DATA_W: data-stage request.
- `dm_gnt` output 1, `dm_rvalid` output 1, `dm_rdata` output DATA_W.
- `dbg_req` input 1, `dbg_we` input 1, `dbg_addr` input ADDR_W, `dbg_wdata` input DATA_W: debug request.
- `dbg_gnt` output 1, `dbg_rvalid` output 1, `dbg_rdata` output DATA_W.
- `mem_en` output 1, `mem_we` output 1, `mem_addr` output ADDR_W, `mem_wdata` output DATA_W: memory command.
- `mem_rdata` input DATA_W: memory read data, valid one cycle after a read command.

## Operation
- Exactly one requester wins per cycle. Grants are combinational from the current requests and registered state.
- The memory command (`mem_en`, `mem_we`, `mem_addr`, `mem_wdata`) is a mux of the winner's signals. If there is no winner, `mem_en`=0 and `mem_we`=0.
- Base priority: DM > IF > DBG.
- Promotion overrides base priority, in this order (first match wins):
  1. `halted`=1 and `dbg_req`: DBG wins.
  2. IF wait counter == STARVE_MAX and `if_req`: IF wins.
  3. DBG wait counter == STARVE_MAX and `dbg_req`: DBG wins.
  4. Otherwise base priority applies.
- Wait counters (IF, DBG; 4 bits each):
  - increment on a cycle where the requester has req=1 and gnt=0, saturating at STARVE_MAX;
  - clear to 0 when granted or when req=0.
- A denied DM request is a stall; the pipeline holds `dm_*` stable. A denied IF request is likewise held.
- Writes: the memory write occurs in the grant cycle. A write never produces an rvalid.
- Reads:
  - A granted read registers the owner ID (IF/DM/DBG) and a pending flag.
  - Next cycle, exactly that owner's `*_rvalid`=1.
  - All `*_rdata` outputs are wired to `mem_rdata`; only the rvalid qualifies them.
- Back-to-back reads by different owners are legal every cycle. Each rvalid follows its own grant by exactly one cycle.

## Timing
- Grant latency: 0 cycles (same cycle as req).
- Read data latency: 1 cycle after grant.
- Throughput: one access per cycle.
- Reset values: both wait counters 0, pending flag 0, owner 0, all `*_rvalid` 0. Grants and `mem_*` are combinational and follow inputs even during reset, except `mem_en`=0, `mem_we`=0 and all grants=0 while `rst`=1.
- Reset asserted the cycle after a read grant: the pending read is dropped and no rvalid is issued.
- `halted` changing mid-stream takes effect in the same cycle's arbitration. A DBG wait counter already at STARVE_MAX is unaffected by `halted`.
- Simultaneous promotion of IF and DBG with `halted`=0: IF wins. DBG's counter stays saturated and DBG wins the next cycle if IF's promotion has cleared.

## Configuration
- `MEM_ARB_DBG_EN` defined: debug port is arbitrated as described above.
- `MEM_ARB_DBG_EN` undefined:
  - `dbg_*` inputs are ignored;
  - `dbg_gnt` and `dbg_rvalid` are tied to 0;
  - the DBG wait counter and halted promotion are removed;
  - arbitration reduces to DM > IF with IF promotion.

## Test plan
- IF-only read, memory word 0 = 32'h28010078, `if_addr`=0 → `if_gnt`=1 the same cycle; next cycle `if_rvalid`=1, `if_rdata`=32'h28010078, `dm_rvalid`=`dbg_rvalid`=0.
- `dm_req`, `dm_we`=1, `dm_addr`=121, `dm_wdata`=130 together with `if_req` → `dm_gnt`=1, `if_gnt`=0, `mem_we`=1, `mem_addr`=121; no rvalid the next cycle.
- `dm_req` held continuously with `if_req` held, STARVE_MAX=4 → IF denied 4 cycles, `if_gnt`=1 on cycle 5, then DM wins again the next cycle.
- `halted`=1 with all three reading (IF addr 0, DM addr 120, DBG addr 121) → `dbg_gnt`=1; next cycle `dbg_rvalid`=1 only.
- Read granted to DM at addr 120 (memory word 120 = 85), `rst` pulsed the next cycle → `dm_rvalid` stays 0 and both counters read 0 after reset.
- `MEM_ARB_DBG_EN` undefined, `halted`=1, `dbg_req` and `if_req` → `if_gnt`=1, `dbg_gnt`=0, `dbg_rvalid` never asserts.

Source files
------------

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares one single-port memory between instruction fetch (IF),
// data access (DM) and a debug/loader port (DBG).
//
// Arbitration is fixed priority (DM > IF > DBG) with starvation aging for IF and DBG.
// A halted core hands the port to DBG. Grants are combinational. Read data returns one
// cycle after the grant, and the read owner is tracked so that only one rvalid fires.
//
// Build option: define MEM_ARB_DBG_EN to arbitrate the debug port. When it is not
// defined, the dbg_* inputs and halted are ignored, and dbg_gnt and dbg_rvalid read 0.
//
// Ports:
//   clk1, rst                               clock, async active-high reset
//   halted                                  core HALTED flag (DBG promotion)
//   if_req/if_addr -> if_gnt/if_rvalid/if_rdata
//   dm_req/dm_we/dm_addr/dm_wdata -> dm_gnt/dm_rvalid/dm_rdata
//   dbg_req/dbg_we/dbg_addr/dbg_wdata -> dbg_gnt/dbg_rvalid/dbg_rdata
//   mem_en/mem_we/mem_addr/mem_wdata        memory command (winner's request)
//   mem_rdata                               memory read data, one cycle after a read
module mips_mem_arbiter #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              halted,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        OWN_IF  = 2'd0,
        OWN_DM  = 2'd1,
        OWN_DBG = 2'd2
    } owner_e;

    logic [CNT_W-1:0] if_wait_q, if_wait_d;
    logic             pend_q, pend_d;
    owner_e           owner_q, owner_d;
`ifdef MEM_ARB_DBG_EN
    logic [CNT_W-1:0] dbg_wait_q, dbg_wait_d;
`else
    // Debug inputs are intentionally ignored in this build.
    logic unused_dbg;
    assign unused_dbg = ^{halted, dbg_req, dbg_we, dbg_addr, dbg_wdata};
`endif

    // Winner selection: promotions first, then base priority DM > IF > DBG.
    always_comb begin
        if_gnt  = 1'b0;
        dm_gnt  = 1'b0;
        dbg_gnt = 1'b0;
        if (!rst) begin
`ifdef MEM_ARB_DBG_EN
            if (halted && dbg_req)                       dbg_gnt = 1'b1;
            else if (if_req && (if_wait_q == CNT_MAX))   if_gnt  = 1'b1;
            else if (dbg_req && (dbg_wait_q == CNT_MAX)) dbg_gnt = 1'b1;
            else if (dm_req)                             dm_gnt  = 1'b1;
            else if (if_req)                             if_gnt  = 1'b1;
            else if (dbg_req)                            dbg_gnt = 1'b1;
`else
            if (if_req && (if_wait_q == CNT_MAX)) if_gnt = 1'b1;
            else if (dm_req)                      dm_gnt = 1'b1;
            else if (if_req)                      if_gnt = 1'b1;
`endif
        end
    end

    // Memory command mux driven from the one-hot grant.
    always_comb begin
        mem_en    = if_gnt | dm_gnt | dbg_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (dm_gnt) begin
            mem_we    = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end else if (if_gnt) begin
            mem_addr  = if_addr;
        end else if (dbg_gnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    // Next state: saturating wait counters and read-owner tracking.
    always_comb begin
        if_wait_d = '0;
        if (if_req && !if_gnt)
            if_wait_d = (if_wait_q >= CNT_MAX) ? CNT_MAX : if_wait_q + CNT_W'(1);
`ifdef MEM_ARB_DBG_EN
        dbg_wait_d = '0;
        if (dbg_req && !dbg_gnt)
            dbg_wait_d = (dbg_wait_q >= CNT_MAX) ? CNT_MAX : dbg_wait_q + CNT_W'(1);
`endif
        pend_d  = mem_en && !mem_we;
        owner_d = owner_q;
        if (dm_gnt)       owner_d = OWN_DM;
        else if (if_gnt)  owner_d = OWN_IF;
        else if (dbg_gnt) owner_d = OWN_DBG;
    end

    // State registers; reset also drops any read still in flight.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            if_wait_q  <= '0;
            pend_q     <= 1'b0;
            owner_q    <= OWN_IF;
`ifdef MEM_ARB_DBG_EN
            dbg_wait_q <= '0;
`endif
        end else begin
            if_wait_q  <= if_wait_d;
            pend_q     <= pend_d;
            owner_q    <= owner_d;
`ifdef MEM_ARB_DBG_EN
            dbg_wait_q <= dbg_wait_d;
`endif
        end
    end

    assign if_rvalid = pend_q && (owner_q == OWN_IF);
    assign dm_rvalid = pend_q && (owner_q == OWN_DM);
`ifdef MEM_ARB_DBG_EN
    assign dbg_rvalid = pend_q && (owner_q == OWN_DBG);
`else
    assign dbg_rvalid = 1'b0;
`endif

    // Read data is shared; each rvalid qualifies it for its owner.
    assign if_rdata  = mem_rdata;
    assign dm_rdata  = mem_rdata;
    assign dbg_rdata = mem_rdata;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Testbench for mips_mem_arbiter: directed scenarios, then random traffic, all checked
// against a requester-level reference model. Also builds with MEM_ARB_DBG_EN defined.
module tb_mips_mem_arbiter;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SM     = 4;

    // Requester indices used by the model.
    localparam int R_IF = 0, R_DM = 1, R_DBG = 2, R_NONE = 3;

    logic              clk1 = 1'b0;
    logic              rst;
    logic              halted;
    logic              if_req, if_gnt, if_rvalid;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata, dm_rdata;
    logic              dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata, dbg_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;

    always #5 clk1 = ~clk1;

    mips_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(SM)) dut (
        .clk1(clk1), .rst(rst), .halted(halted),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Power-on memory contents used by both the memory and the model.
    function automatic logic [31:0] init_val(input int a);
        if (a == 0)   return 32'h28010078;
        if (a == 120) return 32'd85;
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Single-port synchronous memory behind the arbiter.
    logic [31:0] tb_mem [0:1023];
    bit          tb_wr  [0:1023];
    always @(posedge clk1) begin
        if (mem_en && !mem_we)
            mem_rdata <= tb_wr[mem_addr] ? tb_mem[mem_addr] : init_val(int'(mem_addr));
        if (mem_en && mem_we) begin
            tb_mem[mem_addr] <= mem_wdata;
            tb_wr[mem_addr]  <= 1'b1;
        end
    end

    // Reference model state.
    int          m_if_wait, m_dbg_wait, m_owner;
    bit          m_pend;
    logic [31:0] m_pdata;
    logic [31:0] sh_mem [0:1023];
    int          total = 0, bad = 0;
    logic        cap_if_gnt, cap_dm_gnt, cap_dbg_gnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Who should own the port this cycle, straight from the priority rules.
    function automatic int expected_winner();
        bit dbg_on;
`ifdef MEM_ARB_DBG_EN
        dbg_on = 1'b1;
`else
        dbg_on = 1'b0;
`endif
        if (rst)                                    return R_NONE;
        if (dbg_on && halted && dbg_req)            return R_DBG;
        if (if_req && m_if_wait == int'(SM))        return R_IF;
        if (dbg_on && dbg_req && m_dbg_wait == int'(SM)) return R_DBG;
        if (dm_req)                                 return R_DM;
        if (if_req)                                 return R_IF;
        if (dbg_on && dbg_req)                      return R_DBG;
        return R_NONE;
    endfunction

    function automatic int sat_inc(input int v);
        return (v + 1 > int'(SM)) ? int'(SM) : v + 1;
    endfunction

    // One clock cycle with the inputs as currently driven: check, clock, update model.
    task automatic step();
        int          w, a;
        bit          wr;
        logic [31:0] wd;
        logic [31:0] owner_rdata;
        #1;
        if (rst) begin
            m_if_wait = 0; m_dbg_wait = 0; m_pend = 0;
        end
        w  = expected_winner();
        wr = (w == R_DM && dm_we) || (w == R_DBG && dbg_we);
        a  = (w == R_IF) ? int'(if_addr) : (w == R_DM) ? int'(dm_addr) : int'(dbg_addr);
        wd = (w == R_DM) ? dm_wdata : dbg_wdata;
        cap_if_gnt = if_gnt; cap_dm_gnt = dm_gnt; cap_dbg_gnt = dbg_gnt;
        chk("if_gnt",  64'(if_gnt),  64'(w == R_IF));
        chk("dm_gnt",  64'(dm_gnt),  64'(w == R_DM));
        chk("dbg_gnt", 64'(dbg_gnt), 64'(w == R_DBG));
        chk("mem_en",  64'(mem_en),  64'(w != R_NONE));
        chk("mem_we",  64'(mem_we),  64'(wr));
        if (w != R_NONE) chk("mem_addr", 64'(mem_addr), 64'(a));
        if (wr)          chk("mem_wdata", 64'(mem_wdata), 64'(wd));
        chk("if_rvalid",  64'(if_rvalid),  64'(m_pend && m_owner == R_IF));
        chk("dm_rvalid",  64'(dm_rvalid),  64'(m_pend && m_owner == R_DM));
        chk("dbg_rvalid", 64'(dbg_rvalid), 64'(m_pend && m_owner == R_DBG));
        if (m_pend) begin
            owner_rdata = (m_owner == R_IF) ? if_rdata : (m_owner == R_DM) ? dm_rdata : dbg_rdata;
            chk("rdata", 64'(owner_rdata), 64'(m_pdata));
        end
        @(posedge clk1);
        if (rst) begin
            m_if_wait = 0; m_dbg_wait = 0; m_pend = 0;
        end else begin
            m_if_wait  = (if_req && w != R_IF) ? sat_inc(m_if_wait) : 0;
            m_dbg_wait = (dbg_req && w != R_DBG) ? sat_inc(m_dbg_wait) : 0;
            m_pend     = (w != R_NONE) && !wr;
            m_owner    = w;
            if (m_pend) m_pdata = sh_mem[a];
            if (wr)     sh_mem[a] = wd;
        end
        @(negedge clk1);
    endtask

    task automatic idle_inputs();
        halted = 0; if_req = 0; if_addr = '0;
        dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) sh_mem[i] = init_val(i);
        m_if_wait = 0; m_dbg_wait = 0; m_pend = 0; m_owner = 0; m_pdata = '0;
        rst = 1'b0;
        idle_inputs();
        #2 rst = 1'b1;

        // Reset: everything requesting, yet no grant and no memory command.
        halted = 1; if_req = 1; dm_req = 1; dm_we = 1; dbg_req = 1; dbg_we = 1;
        step();
        chk("rst_if_rvalid", 64'(if_rvalid), 64'(0));
        rst = 1'b0;
        idle_inputs();
        step();

        // IF-only read of word 0.
        if_req = 1; if_addr = '0;
        step();
        chk("tp1_if_gnt", 64'(cap_if_gnt), 64'(1));
        if_req = 0;
        chk("tp1_if_rvalid", 64'(if_rvalid), 64'(1));
        chk("tp1_if_rdata",  64'(if_rdata),  64'(32'h28010078));
        chk("tp1_dm_rvalid", 64'(dm_rvalid), 64'(0));
        step();

        // DM write beats IF; writes never produce rvalid.
        dm_req = 1; dm_we = 1; dm_addr = 10'd121; dm_wdata = 32'd130;
        if_req = 1; if_addr = 10'd4;
        step();
        chk("tp2_dm_gnt", 64'(cap_dm_gnt), 64'(1));
        chk("tp2_if_gnt", 64'(cap_if_gnt), 64'(0));
        chk("tp2_dm_rvalid", 64'(dm_rvalid), 64'(0));
        chk("tp2_if_rvalid", 64'(if_rvalid), 64'(0));
        idle_inputs();
        step();
        dm_req = 1; dm_addr = 10'd121;
        step();
        dm_req = 0;
        chk("tp2_readback", 64'(dm_rdata), 64'(130));
        step();

        // Starvation: IF denied four cycles, granted on the fifth, then DM again.
        dm_req = 1; dm_addr = 10'd7; if_req = 1; if_addr = 10'd8;
        for (int c = 0; c < 6; c++) begin
            step();
            chk($sformatf("starve_c%0d_if_gnt", c + 1), 64'(cap_if_gnt), 64'(c == 4));
        end
        idle_inputs();
        step();

`ifdef MEM_ARB_DBG_EN
        // Halted core hands the port to DBG.
        halted = 1; if_req = 1; if_addr = '0; dm_req = 1; dm_addr = 10'd120;
        dbg_req = 1; dbg_addr = 10'd121;
        step();
        chk("tp4_dbg_gnt", 64'(cap_dbg_gnt), 64'(1));
        idle_inputs();
        chk("tp4_dbg_rvalid", 64'(dbg_rvalid), 64'(1));
        chk("tp4_dbg_rdata",  64'(dbg_rdata),  64'(130));
        chk("tp4_if_rvalid",  64'(if_rvalid),  64'(0));
        step();
`else
        // Debug port disabled: halted has no effect and DBG is never served.
        halted = 1; dbg_req = 1; dbg_addr = 10'd121; if_req = 1; if_addr = '0;
        step();
        chk("tp6_if_gnt",  64'(cap_if_gnt),  64'(1));
        chk("tp6_dbg_gnt", 64'(cap_dbg_gnt), 64'(0));
        if_req = 0;
        step();
        chk("tp6_dbg_rvalid", 64'(dbg_rvalid), 64'(0));
        idle_inputs();
        step();
`endif

        // Reset right after a DM read grant drops the read.
        dm_req = 1; dm_addr = 10'd120;
        step();
        dm_req = 0; rst = 1;
        step();
        chk("tp5_dm_rvalid", 64'(dm_rvalid), 64'(0));
        rst = 0;
        step();
        chk("tp5_dm_rvalid_after", 64'(dm_rvalid), 64'(0));
        dm_req = 1; dm_addr = 10'd120; if_req = 1; if_addr = 10'd3;
        step();
        chk("tp5_dm_wins", 64'(cap_dm_gnt), 64'(1));

        // Random traffic; addresses kept small so reads hit earlier writes.
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 79) == 0);
            halted    = ($urandom_range(0, 3) == 0);
            if_req    = ($urandom_range(0, 3) != 0);
            if_addr   = ADDR_W'($urandom_range(0, 127));
            dm_req    = ($urandom_range(0, 2) != 0);
            dm_we     = $urandom_range(0, 1) == 1;
            dm_addr   = ADDR_W'($urandom_range(0, 127));
            dm_wdata  = $urandom;
            dbg_req   = $urandom_range(0, 1) == 1;
            dbg_we    = $urandom_range(0, 1) == 1;
            dbg_addr  = ADDR_W'($urandom_range(0, 127));
            dbg_wdata = $urandom;
            step();
        end
        rst = 0;
        idle_inputs();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
